// File: rtl/dcache_pkg.sv
// Shared definitions for the N-way data cache controller: request kinds,
// FSM state encoding and a width helper for derived index parameters.
package dcache_pkg;

    localparam logic [2:0] KIND_RD         = 3'd0;
    localparam logic [2:0] KIND_WR         = 3'd1;
    localparam logic [2:0] KIND_IDX_INV    = 3'd2;
    localparam logic [2:0] KIND_HIT_INV    = 3'd3;
    localparam logic [2:0] KIND_HIT_WB_INV = 3'd4;
    localparam logic [2:0] KIND_HIT_WB     = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WB     = 3'd1,
        ST_RREQ   = 3'd2,
        ST_FILL   = 3'd3,
        ST_COMMIT = 3'd4,
        ST_CLEAN  = 3'd5
    } state_t;

    // Index width that never collapses to zero bits, so WAYS=1 / LINE_BEATS=1 still elaborate.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/dcache_victim_sel.sv
// Replacement victim choice: the lowest-index invalid way if any, otherwise the LRU way.
module dcache_victim_sel
    import dcache_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int WAY_W = clog2_min1(WAYS)
) (
    input  logic [WAYS-1:0]  valid_vec,
    input  logic [WAY_W-1:0] lru_way,
    output logic [WAY_W-1:0] victim_idx,
    output logic [WAYS-1:0]  victim_oh
);

    always_comb begin
        victim_idx = lru_way;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_vec[i]) victim_idx = WAY_W'(i);
        end
        for (int i = 0; i < WAYS; i++) begin
            victim_oh[i] = (victim_idx == WAY_W'(i));
        end
    end

endmodule

// File: rtl/dcache_ctrl_nway.sv
// Control FSM for a WAYS-way write-back, write-allocate L1 data cache with
// multi-beat refill/writeback over a valid/ready burst memory port.
module dcache_ctrl_nway
    import dcache_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int LINE_BEATS = 4,
    parameter int WAY_W      = clog2_min1(WAYS),
    parameter int BEAT_W     = clog2_min1(LINE_BEATS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [2:0]        req_kind,
    input  logic [WAY_W-1:0]  req_way,
    input  logic [WAYS-1:0]   hit_vec,
    input  logic [WAYS-1:0]   valid_vec,
    input  logic [WAYS-1:0]   dirty_vec,
    input  logic [WAY_W-1:0]  lru_way,
    output logic              resp_valid,
    output logic              busy,
    output logic [WAYS-1:0]   way_sel,
    output logic              tag_we,
    output logic              valid_we,
    output logic              valid_wd,
    output logic              dirty_we,
    output logic              dirty_wd,
    output logic              data_we,
    output logic              data_src,
    output logic [BEAT_W-1:0] data_beat,
    output logic              lru_we,
    output logic              mem_req_valid,
    output logic              mem_we,
    input  logic              mem_req_ready,
    output logic              mem_addr_sel,
    output logic [BEAT_W-1:0] mem_beat,
    input  logic              mem_rvalid
);

    // Memory handshake: a request/write beat transfers on a cycle where
    // mem_req_valid && mem_req_ready; once raised, mem_req_valid and its
    // attributes hold until that transfer. Read beats arrive on mem_rvalid
    // with no back-pressure and are always consumed in FILL.
    state_t             state, state_nx;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [WAY_W-1:0]   way_q;
    logic [WAYS-1:0]    way_q_oh, req_way_oh;
    logic [WAY_W-1:0]   victim_idx, hit_idx;
    logic [WAYS-1:0]    victim_oh;
    logic               hit, hit_dirty, victim_dirty;
    logic               is_line_kind, is_wb_kind, miss_start, wb_start, last_beat;

    dcache_victim_sel #(.WAYS(WAYS), .WAY_W(WAY_W)) u_victim (
        .valid_vec  (valid_vec),
        .lru_way    (lru_way),
        .victim_idx (victim_idx),
        .victim_oh  (victim_oh)
    );

    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (hit_vec[i]) hit_idx = WAY_W'(i);
        end
        for (int i = 0; i < WAYS; i++) begin
            way_q_oh[i]   = (way_q == WAY_W'(i));
            req_way_oh[i] = (req_way == WAY_W'(i));
        end
    end

    assign hit          = |hit_vec;
    assign hit_dirty    = |(hit_vec & dirty_vec);
    // An invalid line never needs writing back, whatever its stale dirty bit says.
    assign victim_dirty = |(victim_oh & valid_vec & dirty_vec);
    assign is_line_kind = (req_kind == KIND_RD) || (req_kind == KIND_WR);
    assign is_wb_kind   = (req_kind == KIND_HIT_WB) || (req_kind == KIND_HIT_WB_INV);
    assign miss_start   = req_valid && is_line_kind && !hit;
    assign wb_start     = req_valid && is_wb_kind && hit_dirty;
    assign last_beat    = (beat_cnt == BEAT_W'(LINE_BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (miss_start)    state_nx = victim_dirty ? ST_WB : ST_RREQ;
                else if (wb_start) state_nx = ST_WB;
            end
            ST_WB:     if (mem_req_ready && last_beat) state_nx = is_line_kind ? ST_RREQ : ST_CLEAN;
            ST_RREQ:   if (mem_req_ready) state_nx = ST_FILL;
            ST_FILL:   if (mem_rvalid && last_beat) state_nx = ST_COMMIT;
            ST_COMMIT: state_nx = ST_IDLE;
            ST_CLEAN:  state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // way_q holds the refill victim for misses, or the hit way for HIT_WB*.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            way_q    <= '0;
        end else if (state == ST_IDLE) begin
            beat_cnt <= '0;
            if (miss_start)    way_q <= victim_idx;
            else if (wb_start) way_q <= hit_idx;
        end else if ((state == ST_WB && mem_req_ready) || (state == ST_FILL && mem_rvalid)) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
        end
    end

    always_comb begin
        resp_valid    = 1'b0;
        busy          = 1'b0;
        way_sel       = '0;
        tag_we        = 1'b0;
        valid_we      = 1'b0;
        valid_wd      = 1'b0;
        dirty_we      = 1'b0;
        dirty_wd      = 1'b0;
        data_we       = 1'b0;
        data_src      = 1'b0;
        data_beat     = '0;
        lru_we        = 1'b0;
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        mem_beat      = '0;
        if (!rst) begin
            busy = (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        case (req_kind)
                            KIND_RD, KIND_WR: begin
                                if (hit) begin
                                    resp_valid = 1'b1;
                                    lru_we     = 1'b1;
                                    way_sel    = hit_vec;
                                    if (req_kind == KIND_WR) begin
                                        data_we  = 1'b1;
                                        data_src = 1'b1;
                                        dirty_we = 1'b1;
                                        dirty_wd = 1'b1;
                                    end
                                end
                            end
                            KIND_IDX_INV: begin
                                resp_valid = 1'b1;
                                valid_we   = 1'b1;
                                way_sel    = req_way_oh;
                            end
                            KIND_HIT_INV: begin
                                resp_valid = 1'b1;
                                if (hit) begin
                                    valid_we = 1'b1;
                                    way_sel  = hit_vec;
                                end
                            end
                            KIND_HIT_WB_INV: begin
                                if (!hit_dirty) begin
                                    resp_valid = 1'b1;
                                    if (hit) begin
                                        valid_we = 1'b1;
                                        way_sel  = hit_vec;
                                    end
                                end
                            end
                            KIND_HIT_WB: resp_valid = !hit_dirty;
                            default:     resp_valid = 1'b1;
                        endcase
                    end
                end
                ST_WB: begin
                    way_sel       = way_q_oh;
                    data_beat     = beat_cnt;
                    mem_req_valid = 1'b1;
                    mem_we        = 1'b1;
                    mem_addr_sel  = is_line_kind;
                    mem_beat      = beat_cnt;
                end
                ST_RREQ: mem_req_valid = 1'b1;
                ST_FILL: begin
                    if (mem_rvalid) begin
                        way_sel   = way_q_oh;
                        data_we   = 1'b1;
                        data_beat = beat_cnt;
                    end
                end
                ST_COMMIT: begin
                    way_sel  = way_q_oh;
                    tag_we   = 1'b1;
                    valid_we = 1'b1;
                    valid_wd = 1'b1;
                    dirty_we = 1'b1;
                    lru_we   = 1'b1;
                end
                ST_CLEAN: begin
                    way_sel = way_q_oh;
                    if (req_kind == KIND_HIT_WB_INV) valid_we = 1'b1;
                    else                             dirty_we = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl_nway.sv
// Directed bench for dcache_ctrl_nway: three configurations (2-way/4-beat,
// 4-way/4-beat, 1-way/1-beat) driven cycle by cycle against hand-computed outputs.
module tb_dcache_ctrl_nway;

    localparam logic [2:0] K_RD = 3'd0, K_WR = 3'd1, K_IDX_INV = 3'd2, K_HIT_INV = 3'd3;
    localparam logic [2:0] K_HWBI = 3'd4, K_HWB = 3'd5;

    // Output bundle layout shared by all three instances (way_sel/beats zero-extended).
    localparam logic [24:0] RESP = 25'h1 << 24, BUSY = 25'h1 << 23;
    localparam logic [24:0] TAG  = 25'h1 << 14, VWE  = 25'h1 << 13, VWD = 25'h1 << 12;
    localparam logic [24:0] DYWE = 25'h1 << 11, DYWD = 25'h1 << 10;
    localparam logic [24:0] DWE  = 25'h1 << 9,  DSRC = 25'h1 << 8,  LRU = 25'h1 << 5;
    localparam logic [24:0] MRV  = 25'h1 << 4,  MWE  = 25'h1 << 3,  MSEL = 25'h1 << 2;

    function automatic logic [24:0] ws(input logic [7:0] w);
        return {2'b0, w, 15'b0};
    endfunction
    function automatic logic [24:0] db(input logic [1:0] b);
        return {17'b0, b, 6'b0};
    endfunction
    function automatic logic [24:0] mb(input logic [1:0] b);
        return {23'b0, b};
    endfunction

    logic       clk = 1'b0;
    logic       rst;
    logic       rv_a, rv_b, rv_c;
    logic [2:0] kind, req_way, lru;
    logic [7:0] hit, valid, dirty;
    logic       rdy, rvalid;
    int         checks = 0;
    int         errors = 0;
    logic [24:0] exp;

    always #5 clk = ~clk;

    // ---------------- instance a: WAYS=2, LINE_BEATS=4 ----------------
    logic       a_resp, a_busy, a_tag, a_vwe, a_vwd, a_dywe, a_dywd, a_dwe, a_dsrc, a_lru;
    logic       a_mrv, a_mwe, a_msel;
    logic [1:0] a_ws, a_db, a_mb;
    logic [24:0] a_obs;
    assign a_obs = {a_resp, a_busy, 6'b0, a_ws, a_tag, a_vwe, a_vwd, a_dywe, a_dywd, a_dwe, a_dsrc,
                    a_db, a_lru, a_mrv, a_mwe, a_msel, a_mb};

    dcache_ctrl_nway #(.WAYS(2), .LINE_BEATS(4)) dut_a (
        .clk(clk), .rst(rst), .req_valid(rv_a), .req_kind(kind), .req_way(req_way[0:0]),
        .hit_vec(hit[1:0]), .valid_vec(valid[1:0]), .dirty_vec(dirty[1:0]), .lru_way(lru[0:0]),
        .resp_valid(a_resp), .busy(a_busy), .way_sel(a_ws), .tag_we(a_tag), .valid_we(a_vwe),
        .valid_wd(a_vwd), .dirty_we(a_dywe), .dirty_wd(a_dywd), .data_we(a_dwe), .data_src(a_dsrc),
        .data_beat(a_db), .lru_we(a_lru), .mem_req_valid(a_mrv), .mem_we(a_mwe),
        .mem_req_ready(rdy), .mem_addr_sel(a_msel), .mem_beat(a_mb), .mem_rvalid(rvalid)
    );

    // ---------------- instance b: WAYS=4, LINE_BEATS=4 ----------------
    logic       b_resp, b_busy, b_tag, b_vwe, b_vwd, b_dywe, b_dywd, b_dwe, b_dsrc, b_lru;
    logic       b_mrv, b_mwe, b_msel;
    logic [3:0] b_ws;
    logic [1:0] b_db, b_mb;
    logic [24:0] b_obs;
    assign b_obs = {b_resp, b_busy, 4'b0, b_ws, b_tag, b_vwe, b_vwd, b_dywe, b_dywd, b_dwe, b_dsrc,
                    b_db, b_lru, b_mrv, b_mwe, b_msel, b_mb};

    dcache_ctrl_nway #(.WAYS(4), .LINE_BEATS(4)) dut_b (
        .clk(clk), .rst(rst), .req_valid(rv_b), .req_kind(kind), .req_way(req_way[1:0]),
        .hit_vec(hit[3:0]), .valid_vec(valid[3:0]), .dirty_vec(dirty[3:0]), .lru_way(lru[1:0]),
        .resp_valid(b_resp), .busy(b_busy), .way_sel(b_ws), .tag_we(b_tag), .valid_we(b_vwe),
        .valid_wd(b_vwd), .dirty_we(b_dywe), .dirty_wd(b_dywd), .data_we(b_dwe), .data_src(b_dsrc),
        .data_beat(b_db), .lru_we(b_lru), .mem_req_valid(b_mrv), .mem_we(b_mwe),
        .mem_req_ready(rdy), .mem_addr_sel(b_msel), .mem_beat(b_mb), .mem_rvalid(rvalid)
    );

    // ---------------- instance c: WAYS=1, LINE_BEATS=1 ----------------
    logic       c_resp, c_busy, c_tag, c_vwe, c_vwd, c_dywe, c_dywd, c_dwe, c_dsrc, c_lru;
    logic       c_mrv, c_mwe, c_msel;
    logic [0:0] c_ws, c_db, c_mb;
    logic [24:0] c_obs;
    assign c_obs = {c_resp, c_busy, 7'b0, c_ws, c_tag, c_vwe, c_vwd, c_dywe, c_dywd, c_dwe, c_dsrc,
                    1'b0, c_db, c_lru, c_mrv, c_mwe, c_msel, 1'b0, c_mb};

    dcache_ctrl_nway #(.WAYS(1), .LINE_BEATS(1)) dut_c (
        .clk(clk), .rst(rst), .req_valid(rv_c), .req_kind(kind), .req_way(req_way[0:0]),
        .hit_vec(hit[0:0]), .valid_vec(valid[0:0]), .dirty_vec(dirty[0:0]), .lru_way(lru[0:0]),
        .resp_valid(c_resp), .busy(c_busy), .way_sel(c_ws), .tag_we(c_tag), .valid_we(c_vwe),
        .valid_wd(c_vwd), .dirty_we(c_dywe), .dirty_wd(c_dywd), .data_we(c_dwe), .data_src(c_dsrc),
        .data_beat(c_db), .lru_we(c_lru), .mem_req_valid(c_mrv), .mem_we(c_mwe),
        .mem_req_ready(rdy), .mem_addr_sel(c_msel), .mem_beat(c_mb), .mem_rvalid(rvalid)
    );

    task automatic drive_idle();
        rv_a = 1'b0; rv_b = 1'b0; rv_c = 1'b0;
        kind = K_RD; req_way = '0; lru = '0;
        hit = '0; valid = '0; dirty = '0;
        rdy = 1'b0; rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        exp = '0;
        checks++; if (a_obs !== exp) begin errors++; $display("FAIL reset_a: got %h expected %h", a_obs, exp); end
        checks++; if (b_obs !== exp) begin errors++; $display("FAIL reset_b: got %h expected %h", b_obs, exp); end
        checks++; if (c_obs !== exp) begin errors++; $display("FAIL reset_c: got %h expected %h", c_obs, exp); end
    endtask

    task automatic test_rd_miss_fill();
        @(negedge clk); rv_a = 1'b1; kind = K_RD; hit = 8'h00; valid = 8'h00; dirty = 8'h00; lru = 3'd1; rdy = 1'b1; #1;
        exp = '0;
        checks++; if (a_obs !== exp) begin errors++; $display("FAIL rdmiss_idle: got %h expected %h", a_obs, exp); end
        @(negedge clk); #1;
        exp = BUSY | MRV;
        checks++; if (a_obs !== exp) begin errors++; $display("FAIL rdmiss_rreq: got %h expected %h", a_obs, exp); end
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                @(negedge clk); rvalid = 1'b0; #1;
                exp = BUSY;
                checks++; if (a_obs !== exp) begin errors++; $display("FAIL rdmiss_gap: got %h expected %h", a_obs, exp); end
            end
            @(negedge clk); rvalid = 1'b1; #1;
            exp = BUSY | ws(8'h01) | DWE | db(k[1:0]);
            checks++; if (a_obs !== exp) begin errors++; $display("FAIL rdmiss_fill%0d: got %h expected %h", k, a_obs, exp); end
        end
        @(negedge clk); rvalid = 1'b0; #1;
        exp = BUSY | ws(8'h01) | TAG | VWE | VWD | DYWE | LRU;
        checks++; if (a_obs !== exp) begin errors++; $display("FAIL rdmiss_commit: got %h expected %h", a_obs, exp); end
        @(negedge clk); hit = 8'h01; valid = 8'h01; #1;
        exp = RESP | LRU | ws(8'h01);
        checks++; if (a_obs !== exp) begin errors++; $display("FAIL rdmiss_resp: got %h expected %h", a_obs, exp); end
        @(negedge clk); rv_a = 1'b0; hit = 8'h00; #1;
        exp = '0;
        checks++; if (a_obs !== exp) begin errors++; $display("FAIL rdmiss_done: got %h expected %h", a_obs, exp); end
    endtask

    task automatic test_dirty_evict();
        @(negedge clk); rv_b = 1'b1; kind = K_RD; hit = 8'h00; valid = 8'h0f; dirty = 8'h04; lru = 3'd2; rdy = 1'b1; #1;
        exp = '0;
        checks++; if (b_obs !== exp) begin errors++; $display("FAIL evict_idle: got %h expected %h", b_obs, exp); end
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                repeat (2) begin
                    @(negedge clk); rdy = 1'b0; #1;
                    exp = BUSY | ws(8'h04) | db(2'd1) | MRV | MWE | MSEL | mb(2'd1);
                    checks++; if (b_obs !== exp) begin errors++; $display("FAIL evict_stall: got %h expected %h", b_obs, exp); end
                end
            end
            @(negedge clk); rdy = 1'b1; #1;
            exp = BUSY | ws(8'h04) | db(k[1:0]) | MRV | MWE | MSEL | mb(k[1:0]);
            checks++; if (b_obs !== exp) begin errors++; $display("FAIL evict_wb%0d: got %h expected %h", k, b_obs, exp); end
        end
        @(negedge clk); rdy = 1'b0; #1;
        exp = BUSY | MRV;
        checks++; if (b_obs !== exp) begin errors++; $display("FAIL evict_rreq_wait: got %h expected %h", b_obs, exp); end
        @(negedge clk); rdy = 1'b1; #1;
        checks++; if (b_obs !== exp) begin errors++; $display("FAIL evict_rreq: got %h expected %h", b_obs, exp); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); rvalid = 1'b1; #1;
            exp = BUSY | ws(8'h04) | DWE | db(k[1:0]);
            checks++; if (b_obs !== exp) begin errors++; $display("FAIL evict_fill%0d: got %h expected %h", k, b_obs, exp); end
        end
        @(negedge clk); rvalid = 1'b0; #1;
        exp = BUSY | ws(8'h04) | TAG | VWE | VWD | DYWE | LRU;
        checks++; if (b_obs !== exp) begin errors++; $display("FAIL evict_commit: got %h expected %h", b_obs, exp); end
        @(negedge clk); hit = 8'h04; dirty = 8'h00; #1;
        exp = RESP | LRU | ws(8'h04);
        checks++; if (b_obs !== exp) begin errors++; $display("FAIL evict_resp: got %h expected %h", b_obs, exp); end
        @(negedge clk); rv_b = 1'b0; hit = 8'h00;
    endtask

    task automatic test_wr_hit();
        @(negedge clk); rv_b = 1'b1; kind = K_WR; hit = 8'h08; valid = 8'h0f; dirty = 8'h00; lru = 3'd0; #1;
        exp = RESP | LRU | ws(8'h08) | DWE | DSRC | DYWE | DYWD;
        checks++; if (b_obs !== exp) begin errors++; $display("FAIL wr_hit: got %h expected %h", b_obs, exp); end
        @(negedge clk); dirty = 8'h08; #1;
        checks++; if (b_obs !== exp) begin errors++; $display("FAIL wr_hit_dirty: got %h expected %h", b_obs, exp); end
        @(negedge clk); rv_b = 1'b0; #1;
        exp = '0;
        checks++; if (b_obs !== exp) begin errors++; $display("FAIL wr_hit_drop: got %h expected %h", b_obs, exp); end
    endtask

    task automatic test_hit_wb();
        @(negedge clk); rv_a = 1'b1; kind = K_HWB; hit = 8'h02; valid = 8'h03; dirty = 8'h02; rdy = 1'b1; #1;
        exp = '0;
        checks++; if (a_obs !== exp) begin errors++; $display("FAIL hwb_idle: got %h expected %h", a_obs, exp); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            exp = BUSY | ws(8'h02) | db(k[1:0]) | MRV | MWE | mb(k[1:0]);
            checks++; if (a_obs !== exp) begin errors++; $display("FAIL hwb_wb%0d: got %h expected %h", k, a_obs, exp); end
        end
        @(negedge clk); #1;
        exp = BUSY | ws(8'h02) | DYWE;
        checks++; if (a_obs !== exp) begin errors++; $display("FAIL hwb_clean: got %h expected %h", a_obs, exp); end
        @(negedge clk); dirty = 8'h00; #1;
        exp = RESP;
        checks++; if (a_obs !== exp) begin errors++; $display("FAIL hwb_resp: got %h expected %h", a_obs, exp); end
        @(negedge clk); kind = K_HWBI; hit = 8'h01; #1;
        exp = RESP | ws(8'h01) | VWE;
        checks++; if (a_obs !== exp) begin errors++; $display("FAIL hwbi_clean: got %h expected %h", a_obs, exp); end
        @(negedge clk); rv_a = 1'b0; hit = 8'h00;
    endtask

    task automatic test_inv_ops();
        @(negedge clk); rv_a = 1'b1; kind = K_HIT_INV; hit = 8'h02; valid = 8'h03; dirty = 8'h02; #1;
        exp = RESP | ws(8'h02) | VWE;
        checks++; if (a_obs !== exp) begin errors++; $display("FAIL hinv_hit: got %h expected %h", a_obs, exp); end
        @(negedge clk); hit = 8'h00; #1;
        exp = RESP;
        checks++; if (a_obs !== exp) begin errors++; $display("FAIL hinv_miss: got %h expected %h", a_obs, exp); end
        @(negedge clk); kind = K_IDX_INV; req_way = 3'd1; #1;
        exp = RESP | ws(8'h02) | VWE;
        checks++; if (a_obs !== exp) begin errors++; $display("FAIL idx_inv: got %h expected %h", a_obs, exp); end
        @(negedge clk); kind = 3'd6; hit = 8'h02; #1;
        exp = RESP;
        checks++; if (a_obs !== exp) begin errors++; $display("FAIL kind6: got %h expected %h", a_obs, exp); end
        @(negedge clk); kind = 3'd7; #1;
        checks++; if (a_obs !== exp) begin errors++; $display("FAIL kind7: got %h expected %h", a_obs, exp); end
        @(negedge clk); rv_a = 1'b0; hit = 8'h00; req_way = 3'd0; dirty = 8'h00;
    endtask

    task automatic test_reset_mid_fill();
        @(negedge clk); rv_a = 1'b1; kind = K_RD; hit = 8'h00; valid = 8'h03; dirty = 8'h00; lru = 3'd1; rdy = 1'b1; #1;
        exp = '0;
        checks++; if (a_obs !== exp) begin errors++; $display("FAIL rstf_idle: got %h expected %h", a_obs, exp); end
        @(negedge clk); #1;
        exp = BUSY | MRV;
        checks++; if (a_obs !== exp) begin errors++; $display("FAIL rstf_rreq: got %h expected %h", a_obs, exp); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); rvalid = 1'b1; #1;
            exp = BUSY | ws(8'h02) | DWE | db(k[1:0]);
            checks++; if (a_obs !== exp) begin errors++; $display("FAIL rstf_fill%0d: got %h expected %h", k, a_obs, exp); end
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; rvalid = 1'b0; rv_a = 1'b0; #1;
        exp = '0;
        checks++; if (a_obs !== exp) begin errors++; $display("FAIL rstf_after: got %h expected %h", a_obs, exp); end
        @(negedge clk); rv_a = 1'b1; #1;
        checks++; if (a_obs !== exp) begin errors++; $display("FAIL rstf_restart_idle: got %h expected %h", a_obs, exp); end
        @(negedge clk); #1;
        exp = BUSY | MRV;
        checks++; if (a_obs !== exp) begin errors++; $display("FAIL rstf_restart_rreq: got %h expected %h", a_obs, exp); end
        @(negedge clk); rvalid = 1'b1; #1;
        exp = BUSY | ws(8'h02) | DWE | db(2'd0);
        checks++; if (a_obs !== exp) begin errors++; $display("FAIL rstf_restart_beat0: got %h expected %h", a_obs, exp); end
        @(negedge clk); rvalid = 1'b0; rv_a = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_ways1();
        @(negedge clk); rv_c = 1'b1; kind = K_RD; hit = 8'h00; valid = 8'h01; dirty = 8'h01; lru = 3'd0; rdy = 1'b1; #1;
        exp = '0;
        checks++; if (c_obs !== exp) begin errors++; $display("FAIL w1_idle: got %h expected %h", c_obs, exp); end
        @(negedge clk); #1;
        exp = BUSY | ws(8'h01) | MRV | MWE | MSEL;
        checks++; if (c_obs !== exp) begin errors++; $display("FAIL w1_wb: got %h expected %h", c_obs, exp); end
        @(negedge clk); #1;
        exp = BUSY | MRV;
        checks++; if (c_obs !== exp) begin errors++; $display("FAIL w1_rreq: got %h expected %h", c_obs, exp); end
        @(negedge clk); rvalid = 1'b1; #1;
        exp = BUSY | ws(8'h01) | DWE;
        checks++; if (c_obs !== exp) begin errors++; $display("FAIL w1_fill: got %h expected %h", c_obs, exp); end
        @(negedge clk); rvalid = 1'b0; #1;
        exp = BUSY | ws(8'h01) | TAG | VWE | VWD | DYWE | LRU;
        checks++; if (c_obs !== exp) begin errors++; $display("FAIL w1_commit: got %h expected %h", c_obs, exp); end
        @(negedge clk); hit = 8'h01; dirty = 8'h00; #1;
        exp = RESP | LRU | ws(8'h01);
        checks++; if (c_obs !== exp) begin errors++; $display("FAIL w1_resp: got %h expected %h", c_obs, exp); end
        @(negedge clk); kind = K_IDX_INV; req_way = 3'd0; #1;
        exp = RESP | ws(8'h01) | VWE;
        checks++; if (c_obs !== exp) begin errors++; $display("FAIL w1_idx_inv: got %h expected %h", c_obs, exp); end
        @(negedge clk); rv_c = 1'b0; hit = 8'h00;
    endtask

    initial begin
        test_reset();
        test_rd_miss_fill();
        test_dirty_evict();
        test_wr_hit();
        test_hit_wb();
        test_inv_ops();
        test_reset_mid_fill();
        test_ways1();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
